// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store at a time, alignment/range checking, byte-strobed
// RAM writes, fixed-latency RAM reads with sign/zero extension of the returned lane.
module load_store_unit #(
    parameter logic [31:0] DATA_BASE   = 32'd1024,
    parameter logic [31:0] DATA_LAST   = 32'd2047,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [31:0] load_result_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_en_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wr_data_o,
    output logic        mem_rd_en_o,
    input  logic [31:0] mem_rd_data_i,
    output logic [1:0]  dbg_state_o
);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic           is_load_q, is_load_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     wstrb_q, wstrb_d;
    logic           fault_q, fault_d;
    logic [31:0]    result_q, result_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Legality of the request presented on the inputs this cycle
    logic legal_op, f3_ok, align_ok, range_ok, legal;
    assign legal_op = is_load_i ^ is_store_i;
    assign f3_ok    = is_load_i ? (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                : (funct3_i inside {3'b000, 3'b001, 3'b010});
    assign align_ok = (funct3_i[1:0] == 2'b00) ||
                      ((funct3_i[1:0] == 2'b01) && !addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] == 2'b00));
    assign range_ok = (addr_i >= DATA_BASE) && (addr_i <= DATA_LAST);
    assign legal    = legal_op && f3_ok && align_ok && range_ok;

    logic [3:0]  strb_new;
    logic [31:0] wdata_new;
    always_comb begin
        strb_new  = 4'b1111;
        wdata_new = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                strb_new  = 4'b0001 << addr_i[1:0];
                wdata_new = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                strb_new  = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext_res;
    always_comb begin
        case (addr_q[1:0])
            2'b00:   lane_b = mem_rd_data_i[7:0];
            2'b01:   lane_b = mem_rd_data_i[15:8];
            2'b10:   lane_b = mem_rd_data_i[23:16];
            default: lane_b = mem_rd_data_i[31:24];
        endcase
        lane_h  = addr_q[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];
        ext_res = mem_rd_data_i;
        case (funct3_q[1:0])
            2'b00:   ext_res = funct3_q[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   ext_res = funct3_q[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        fault_d   = fault_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    is_load_d = is_load_i;
                    funct3_d  = funct3_i;
                    addr_d    = addr_i;
                    wdata_d   = wdata_new;
                    wstrb_d   = strb_new;
                    fault_d   = !legal;
                    state_d   = legal ? S_ISSUE : S_RESP;
                    if (!legal) result_d = '0;
                end
            end
            S_ISSUE: begin
                if (is_load_q) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(MEM_LATENCY - 1);
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    result_d = ext_res;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            is_load_q <= 1'b0;
            funct3_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            fault_q   <= 1'b0;
            result_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            fault_q   <= fault_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
        end
    end

    // Strobes are decoded from state so a reset drops them on the very next cycle
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_RESP);
    assign fault_o       = (state_q == S_RESP) && fault_q;
    assign load_result_o = result_q;
    assign mem_addr_o    = {addr_q[31:2], 2'b00};
    assign mem_wr_en_o   = (state_q == S_ISSUE) && !is_load_q;
    assign mem_rd_en_o   = (state_q == S_ISSUE) && is_load_q;
    assign mem_wstrb_o   = mem_wr_en_o ? wstrb_q : 4'b0000;
    assign mem_wr_data_o = wdata_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of requests with expected RAM activity and results,
// a result scoreboard queue, and hand-written reset/busy corner sequences.
module tb_load_store_unit;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, mem_rd_data;
    logic        busy, done, fault, mem_wr_en, mem_rd_en;
    logic [31:0] load_result, mem_addr, mem_wr_data;
    logic [3:0]  mem_wstrb;
    logic [1:0]  dbg_state;

    load_store_unit #(.DATA_BASE(32'd1024), .DATA_LAST(32'd2047), .MEM_LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .is_load_i(is_load), .is_store_i(is_store),
        .funct3_i(funct3), .addr_i(addr), .store_data_i(store_data), .busy_o(busy),
        .done_o(done), .fault_o(fault), .load_result_o(load_result), .mem_addr_o(mem_addr),
        .mem_wr_en_o(mem_wr_en), .mem_wstrb_o(mem_wstrb), .mem_wr_data_o(mem_wr_data),
        .mem_rd_en_o(mem_rd_en), .mem_rd_data_i(mem_rd_data), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a, sd, rd;
        logic        flt;
        logic [3:0]  ws;
        logic [31:0] wd, res;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_res = 32'h0;
    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                                input logic flt, input logic [3:0] ws, input logic [31:0] wd,
                                input logic [31:0] res);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.sd = sd; v.rd = rd;
        v.flt = flt; v.ws = ws; v.wd = wd; v.res = res;
        return v;
    endfunction

    task automatic drive_idle();
        start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        addr = 32'h0; store_data = 32'h0;
    endtask

    task automatic run_req(input vec_t v);
        int k = 0;
        int wr_cnt = 0;
        int rd_cnt = 0;
        bit done_seen = 0;
        bit rd_prev = 0;
        logic [32:0] e;
        logic [31:0] exp_res;
        exp_res = v.flt ? 32'h0 : (v.st && !v.ld ? last_res : v.res);
        last_res = exp_res;
        @(negedge clk);
        start = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
        addr = v.a; store_data = v.sd;
        exp_q.push_back({v.flt, exp_res});
        while (!done_seen && k < 20) begin
            @(negedge clk);
            drive_idle();
            k++;
            mem_rd_data = rd_prev ? v.rd : 32'hBAD0_BAD0;
            #1;
            if (mem_wr_en && mem_rd_en) check("both_strobes", 32'd1, 32'd0);
            if (mem_wr_en) begin
                wr_cnt++;
                check("wr_addr", mem_addr, {v.a[31:2], 2'b00});
                check("wstrb", {28'h0, mem_wstrb}, {28'h0, v.ws});
                check("wr_data", mem_wr_data, v.wd);
            end
            if (mem_rd_en) begin
                rd_cnt++;
                check("rd_addr", mem_addr, {v.a[31:2], 2'b00});
            end
            rd_prev = mem_rd_en;
            if (done) begin
                done_seen = 1;
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("fault", {31'h0, fault}, {31'h0, e[32]});
                    check("load_result", load_result, e[31:0]);
                end
                check("latency", k, v.flt ? 1 : (v.ld ? 2 + LAT : 2));
            end
        end
        if (!done_seen) check("done_timeout", 32'd0, 32'd1);
        check("wr_count", wr_cnt, (!v.flt && v.st) ? 1 : 0);
        check("rd_count", rd_cnt, (!v.flt && v.ld) ? 1 : 0);
        @(negedge clk);
        check("idle_after", {31'h0, busy}, 32'h0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_strobes"}, {26'h0, fault, mem_wr_en, mem_rd_en, mem_wstrb}, 32'h0);
        check({tag, "_load_result"}, load_result, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
    endtask

    initial begin
        vecs[0]  = mk(0, 1, 3'b010, 32'd1028, 32'hDEADBEEF, 0, 0, 4'b1111, 32'hDEADBEEF, 0);
        vecs[1]  = mk(0, 1, 3'b000, 32'd1027, 32'h000000A5, 0, 0, 4'b1000, 32'hA5A5A5A5, 0);
        vecs[2]  = mk(0, 1, 3'b001, 32'd1026, 32'h00001234, 0, 0, 4'b1100, 32'h12341234, 0);
        vecs[3]  = mk(1, 0, 3'b000, 32'd1025, 0, 32'h12348056, 0, 0, 0, 32'hFFFFFF80);
        vecs[4]  = mk(1, 0, 3'b100, 32'd1025, 0, 32'h12348056, 0, 0, 0, 32'h00000080);
        vecs[5]  = mk(1, 0, 3'b001, 32'd1026, 0, 32'h8001ABCD, 0, 0, 0, 32'hFFFF8001);
        vecs[6]  = mk(1, 0, 3'b101, 32'd1026, 0, 32'h8001ABCD, 0, 0, 0, 32'h00008001);
        vecs[7]  = mk(1, 0, 3'b010, 32'd1024, 0, 32'h8001ABCD, 0, 0, 0, 32'h8001ABCD);
        vecs[8]  = mk(0, 1, 3'b010, 32'd2044, 32'h01020304, 0, 0, 4'b1111, 32'h01020304, 0);
        vecs[9]  = mk(1, 0, 3'b010, 32'd1026, 0, 0, 1, 0, 0, 0);
        vecs[10] = mk(0, 1, 3'b001, 32'd1025, 32'h5555, 0, 1, 0, 0, 0);
        vecs[11] = mk(1, 0, 3'b000, 32'd2048, 0, 0, 1, 0, 0, 0);
        vecs[12] = mk(1, 0, 3'b000, 32'd1023, 0, 0, 1, 0, 0, 0);
        vecs[13] = mk(1, 0, 3'b011, 32'd1024, 0, 0, 1, 0, 0, 0);
        vecs[14] = mk(0, 1, 3'b100, 32'd1024, 32'h11, 0, 1, 0, 0, 0);
        vecs[15] = mk(1, 0, 3'b000, 32'd2047, 0, 32'h7F000000, 0, 0, 0, 32'h0000007F);
        vecs[16] = mk(1, 1, 3'b010, 32'd1024, 0, 0, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 3'b010, 32'd1024, 0, 0, 1, 0, 0, 0);
        vecs[18] = mk(0, 1, 3'b000, 32'd1024, 32'hFFFFFF12, 0, 0, 4'b0001, 32'h12121212, 0);
        vecs[19] = mk(0, 1, 3'b001, 32'd1024, 32'hABCD5678, 0, 0, 4'b0011, 32'h56785678, 0);
        vecs[20] = mk(1, 0, 3'b001, 32'd1024, 0, 32'h1234F00D, 0, 0, 0, 32'hFFFFF00D);

        // Clock/reset
        drive_idle();
        mem_rd_data = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        foreach (vecs[i]) run_req(vecs[i]);

        // Random word loads across the legal range
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            logic [31:0] d;
            d = $urandom;
            v = mk(1, 0, 3'b010, 32'd1024 + 4 * $urandom_range(0, 255), 0, d, 0, 0, 0, d);
            run_req(v);
        end

        // Start pulsed while busy: the second request must be dropped
        begin
            int dones = 0;
            int wrs = 0;
            @(negedge clk);
            start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'd1028;
            mem_rd_data = 32'hCAFE0001;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (k <= 2) begin
                    start = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010;
                    addr = 32'd1032; store_data = 32'h0BADF00D;
                end else begin
                    drive_idle();
                end
                #1;
                if (mem_wr_en) wrs++;
                if (done) begin
                    dones++;
                    check("busy_start_result", load_result, 32'hCAFE0001);
                end
            end
            check("busy_start_dones", dones, 1);
            check("busy_start_writes", wrs, 0);
        end

        // Reset during WAIT aborts the load without done
        begin
            int dones = 0;
            int strobes = 0;
            @(negedge clk);
            start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'd1040;
            @(negedge clk);
            drive_idle();
            @(negedge clk);
            check("wait_state", {30'h0, dbg_state}, 32'd2);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset_vals("abort");
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (done) dones++;
                if (mem_wr_en || mem_rd_en) strobes++;
            end
            check("abort_no_done", dones, 0);
            check("abort_no_strobe", strobes, 0);
        end

        check("sb_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
